// File: rtl/vending_pkg.sv
// Shared types and constants for the coffee vending sequencer: FSM state
// encoding, recipe record and lookup, coin values and the default credit cap.
package vending_pkg;

  localparam int         CREDIT_MAX_DEFAULT = 10;
  localparam logic [4:0] COIN_100_VAL       = 5'd1;
  localparam logic [4:0] COIN_500_VAL       = 5'd5;
  localparam logic [2:0] NUM_RECIPES        = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WATER     = 4'd1,
    ST_COFFEE    = 4'd2,
    ST_SUGAR     = 4'd3,
    ST_MILK      = 4'd4,
    ST_CHOCOLATE = 4'd5,
    ST_DONE      = 4'd6,
    ST_REFUND    = 4'd7
  } state_t;

  // Price in credit units, durations in one-second ticks.
  typedef struct packed {
    logic [3:0] price;
    logic [3:0] water;
    logic [3:0] coffee;
    logic [3:0] sugar;
    logic [3:0] milk;
    logic [3:0] chocolate;
  } recipe_t;

  function automatic recipe_t recipe_lookup(input logic [2:0] sel);
    recipe_t r;
    r = '0;
    case (sel)
      3'd0: r = '{price: 4'd3, water: 4'd1, coffee: 4'd2, sugar: 4'd0, milk: 4'd0, chocolate: 4'd0};
      3'd1: r = '{price: 4'd4, water: 4'd3, coffee: 4'd2, sugar: 4'd0, milk: 4'd0, chocolate: 4'd0};
      3'd2: r = '{price: 4'd6, water: 4'd1, coffee: 4'd2, sugar: 4'd1, milk: 4'd2, chocolate: 4'd0};
      3'd3: r = '{price: 4'd8, water: 4'd1, coffee: 4'd2, sugar: 4'd1, milk: 4'd1, chocolate: 4'd2};
      3'd4: r = '{price: 4'd7, water: 4'd1, coffee: 4'd2, sugar: 4'd0, milk: 4'd3, chocolate: 4'd0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // First ingredient step after 'from' with a nonzero duration; DONE if none.
  // Called with ST_IDLE it yields the opening step of the recipe.
  function automatic state_t next_step(input recipe_t r, input state_t from);
    state_t nx;
    nx = ST_DONE;
    if (from < ST_CHOCOLATE && r.chocolate != 4'd0) nx = ST_CHOCOLATE;
    if (from < ST_MILK      && r.milk      != 4'd0) nx = ST_MILK;
    if (from < ST_SUGAR     && r.sugar     != 4'd0) nx = ST_SUGAR;
    if (from < ST_COFFEE    && r.coffee    != 4'd0) nx = ST_COFFEE;
    if (from < ST_WATER     && r.water     != 4'd0) nx = ST_WATER;
    return nx;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Step timer: a TICK_DIV prescaler feeding a seconds counter. 'expired' is
// high during the last clock cycle of a 'target'-second interval; 'restart'
// zeroes both counters so the next cycle is the first of a new interval.
module tick_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [3:0] target,
  output logic       expired
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic [3:0]    secs;
  logic          tick_last;

  assign tick_last = (pre == PRE_LAST);
  assign expired   = tick_last && (secs == target - 4'd1);

  // Prescaler and seconds counter, both cleared on restart.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      secs <= '0;
    end else if (restart) begin
      pre  <= '0;
      secs <= '0;
    end else if (tick_last) begin
      pre  <= '0;
      secs <= secs + 4'd1;
    end else begin
      pre  <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/brew_sequencer.sv
// Coffee vending controller: coin credit, selection check, change latch and
// timed valve sequencing. Optional coin refund on cancel is built when the
// macro COIN_REFUND_EN is defined; otherwise cancel is ignored.
//
// Signalling: coin_100/coin_500 are one-cycle pulses sampled every cycle;
// confirm/cancel are levels acted on at their registered rising edge;
// coin_reject/sel_error are one-cycle registered pulses; all outputs are
// registered and 'state' mirrors the FSM register for debug.
module brew_sequencer
  import vending_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int CREDIT_MAX = CREDIT_MAX_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic [2:0] coffee_type,
  input  logic       confirm,
  input  logic       cancel,
  output logic [3:0] total_coins,
  output logic [3:0] change,
  output logic       water,
  output logic       coffee,
  output logic       sugar,
  output logic       milk,
  output logic       chocolate,
  output logic       finished,
  output logic       coin_reject,
  output logic       sel_error,
  output logic [3:0] state
);

  logic [1:0] rst_sync;
  logic       rst_n;
  logic       confirm_q, confirm_q2, confirm_edge;
  logic       cancel_edge;
  state_t     cur_state, state_nx;
  logic [3:0] credit_nx, change_nx, target;
  logic [2:0] sel_q, sel_nx;
  logic       reject_nx, sel_err_nx, restart, expired;
  logic       coin_any, coin_fits, sel_ok;
  logic [4:0] coin_add, coin_sum;
  recipe_t    cur_rcp, req_rcp;

  // Reset asserts immediately and releases two clocks later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Register confirm and detect its rising edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      confirm_q  <= 1'b0;
      confirm_q2 <= 1'b0;
    end else begin
      confirm_q  <= confirm;
      confirm_q2 <= confirm_q;
    end
  end
  assign confirm_edge = confirm_q & ~confirm_q2;

`ifdef COIN_REFUND_EN
  logic cancel_q, cancel_q2;
  // Register cancel and detect its rising edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cancel_q  <= 1'b0;
      cancel_q2 <= 1'b0;
    end else begin
      cancel_q  <= cancel;
      cancel_q2 <= cancel_q;
    end
  end
  assign cancel_edge = cancel_q & ~cancel_q2;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_edge   = 1'b0;
`endif

  assign cur_rcp   = recipe_lookup(sel_q);
  assign req_rcp   = recipe_lookup(coffee_type);
  assign coin_any  = coin_100 | coin_500;
  assign coin_add  = (coin_100 ? COIN_100_VAL : 5'd0) + (coin_500 ? COIN_500_VAL : 5'd0);
  assign coin_sum  = {1'b0, total_coins} + coin_add;
  assign coin_fits = (coin_sum <= 5'(CREDIT_MAX));
  assign sel_ok    = (coffee_type < NUM_RECIPES) && (total_coins >= req_rcp.price);

  // Next state, credit/change updates, pulse requests and step duration.
  always_comb begin
    state_nx   = cur_state;
    credit_nx  = total_coins;
    change_nx  = change;
    sel_nx     = sel_q;
    reject_nx  = 1'b0;
    sel_err_nx = 1'b0;
    target     = 4'd0;
    case (cur_state)
      ST_IDLE: begin
        if (coin_any) begin
          if (coin_fits) begin
            credit_nx = coin_sum[3:0];
            change_nx = 4'd0;
          end else begin
            reject_nx = 1'b1;
          end
        end
        // An accepted confirm or refund owns credit this cycle; a coin
        // arriving alongside it is turned away.
        if (confirm_edge) begin
          if (sel_ok) begin
            change_nx = total_coins - req_rcp.price;
            credit_nx = 4'd0;
            sel_nx    = coffee_type;
            state_nx  = next_step(req_rcp, ST_IDLE);
            reject_nx = coin_any;
          end else begin
            sel_err_nx = 1'b1;
          end
        end else if (cancel_edge && total_coins != 4'd0) begin
          change_nx = total_coins;
          credit_nx = 4'd0;
          state_nx  = ST_REFUND;
          reject_nx = coin_any;
        end
      end
      ST_WATER, ST_COFFEE, ST_SUGAR, ST_MILK, ST_CHOCOLATE: begin
        reject_nx = coin_any;
        case (cur_state)
          ST_WATER:     target = cur_rcp.water;
          ST_COFFEE:    target = cur_rcp.coffee;
          ST_SUGAR:     target = cur_rcp.sugar;
          ST_MILK:      target = cur_rcp.milk;
          default:      target = cur_rcp.chocolate;
        endcase
        if (expired) state_nx = next_step(cur_rcp, cur_state);
      end
      ST_DONE: begin
        reject_nx = coin_any;
        target    = 4'd1;
        if (expired) state_nx = ST_IDLE;
      end
      default: begin
        reject_nx = coin_any;
        state_nx  = ST_IDLE;
      end
    endcase
  end

  assign restart = (state_nx != cur_state);

  tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clock   (clock),
    .rst_n   (rst_n),
    .restart (restart),
    .target  (target),
    .expired (expired)
  );

  // State, credit/change and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= ST_IDLE;
      total_coins <= 4'd0;
      change      <= 4'd0;
      sel_q       <= 3'd0;
      water       <= 1'b0;
      coffee      <= 1'b0;
      sugar       <= 1'b0;
      milk        <= 1'b0;
      chocolate   <= 1'b0;
      finished    <= 1'b0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
    end else begin
      cur_state   <= state_nx;
      total_coins <= credit_nx;
      change      <= change_nx;
      sel_q       <= sel_nx;
      water       <= (state_nx == ST_WATER);
      coffee      <= (state_nx == ST_COFFEE);
      sugar       <= (state_nx == ST_SUGAR);
      milk        <= (state_nx == ST_MILK);
      chocolate   <= (state_nx == ST_CHOCOLATE);
      finished    <= (state_nx == ST_DONE);
      coin_reject <= reject_nx;
      sel_error   <= sel_err_nx;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_brew_sequencer.sv
// Self-checking bench for brew_sequencer (TICK_DIV = 4). Stimulus tasks push
// expected status events and valve segments into queues; a monitor turns DUT
// outputs into the same events and compares them in order.
module tb_brew_sequencer;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_100 = 1'b0, coin_500 = 1'b0;
  logic [2:0] coffee_type = 3'd0;
  logic       confirm = 1'b0, cancel = 1'b0;
  logic [3:0] total_coins, change, state_dbg;
  logic       water, coffee, sugar, milk, chocolate, finished, coin_reject, sel_error;

  brew_sequencer #(.TICK_DIV(TD), .CREDIT_MAX(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .coin_100    (coin_100),
    .coin_500    (coin_500),
    .coffee_type (coffee_type),
    .confirm     (confirm),
    .cancel      (cancel),
    .total_coins (total_coins),
    .change      (change),
    .water       (water),
    .coffee      (coffee),
    .sugar       (sugar),
    .milk        (milk),
    .chocolate   (chocolate),
    .finished    (finished),
    .coin_reject (coin_reject),
    .sel_error   (sel_error),
    .state       (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference data: price and {water, coffee, sugar, milk, chocolate} seconds
  int price [5]    = '{3, 4, 6, 8, 7};
  int dur   [5][5] = '{'{1,2,0,0,0}, '{3,2,0,0,0}, '{1,2,1,2,0}, '{1,2,1,1,2}, '{1,2,0,3,0}};

  // scoreboard
  logic [9:0]  st_exp_q[$];   // {coin_reject, sel_error, total, change}
  logic [27:0] vlv_exp_q[$];  // {vector, following vector, run length}
  int n_checks = 0;
  int n_fail   = 0;
  int m_credit = 0;
  int m_change = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_st(input bit rej, input bit serr);
    st_exp_q.push_back({rej, serr, 4'(m_credit), 4'(m_change)});
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_total_coins"}, 32'(total_coins), 32'(m_credit));
    check({tag, "_change"}, 32'(change), 32'(m_change));
  endtask

  // monitor: status events and valve/finished run segments
  logic [7:0] prev_tc  = 8'd0;
  logic [5:0] prev_vec = 6'd0;
  int         run_len  = 0;

  always @(negedge clock) begin : mon_blk
    logic [9:0]  st, st_exp;
    logic [5:0]  vec;
    logic [27:0] seg, seg_exp;
    vec = {water, coffee, sugar, milk, chocolate, finished};
    st  = {coin_reject, sel_error, total_coins, change};
    if (mon_en) begin
      if (coin_reject || sel_error || st[7:0] != prev_tc) begin
        n_checks++;
        if (st_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL status_event: unexpected got %h", st);
        end else begin
          st_exp = st_exp_q.pop_front();
          if (st !== st_exp) begin
            n_fail++;
            $display("FAIL status_event: got %h expected %h", st, st_exp);
          end
        end
      end
      if (vec != prev_vec) begin
        if (prev_vec != 6'd0) begin
          seg = {prev_vec, vec, 16'(run_len)};
          n_checks++;
          if (vlv_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL valve_segment: unexpected got %h", seg);
          end else begin
            seg_exp = vlv_exp_q.pop_front();
            if (seg !== seg_exp) begin
              n_fail++;
              $display("FAIL valve_segment: got %h expected %h", seg, seg_exp);
            end
          end
        end
        run_len = 1;
      end else begin
        run_len++;
      end
    end else begin
      run_len = 1;
    end
    prev_tc  = st[7:0];
    prev_vec = vec;
  end

  // driver tasks
  task automatic do_coin(input bit a, input bit b);
    int add;
    add = int'(a) + 5 * int'(b);
    if (m_credit + add > 10) push_st(1'b1, 1'b0);
    else begin
      m_credit += add;
      m_change = 0;
      push_st(1'b0, 1'b0);
    end
    @(negedge clock);
    coin_100 = a;
    coin_500 = b;
    @(negedge clock);
    coin_100 = 1'b0;
    coin_500 = 1'b0;
    check_totals("coin");
  endtask

  task automatic push_segments(input int t, output int s_len);
    int steps[$];
    logic [5:0] v, nxt;
    s_len = 0;
    for (int i = 0; i < 5; i++)
      if (dur[t][i] != 0) begin
        steps.push_back(i);
        s_len += dur[t][i] * TD;
      end
    for (int k = 0; k < steps.size(); k++) begin
      v   = 6'b100000 >> steps[k];
      nxt = (k + 1 < steps.size()) ? (6'b100000 >> steps[k+1]) : 6'b000001;
      vlv_exp_q.push_back({v, nxt, 16'(dur[t][steps[k]] * TD)});
    end
    vlv_exp_q.push_back({6'b000001, 6'b000000, 16'(TD)});
  endtask

  // w_in < 0 picks a random cycle for the mid-brew coin
  task automatic do_confirm(input int t, input bit inj, input int w_in);
    bit ok;
    int s_len, w;
    logic [1:0] cv;
    ok = 1'b0;
    if (t <= 4) ok = (m_credit >= price[t]);
    if (!ok) begin
      push_st(1'b0, 1'b1);
      @(negedge clock);
      coffee_type = 3'(t);
      confirm = 1'b1;
      @(negedge clock);
      @(negedge clock);
      confirm = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check_totals("refused");
      return;
    end
    m_change = m_credit - price[t];
    m_credit = 0;
    push_st(1'b0, 1'b0);
    push_segments(t, s_len);
    w  = (w_in >= 0) ? w_in : int'($urandom_range(0, s_len + TD - 2));
    cv = 2'($urandom_range(1, 3));
    if (inj) push_st(1'b1, 1'b0);
    @(negedge clock);
    coffee_type = 3'(t);
    confirm = 1'b1;
    @(negedge clock);
    @(negedge clock);
    confirm = 1'b0;
    coffee_type = 3'($urandom_range(0, 7));
    for (int k = 0; k <= s_len + TD + 2; k++) begin
      coin_100 = (inj && k == w) ? cv[0] : 1'b0;
      coin_500 = (inj && k == w) ? cv[1] : 1'b0;
      @(negedge clock);
    end
    coin_100 = 1'b0;
    coin_500 = 1'b0;
    check_totals("brew");
  endtask

  task automatic do_cancel();
`ifdef COIN_REFUND_EN
    if (m_credit > 0) begin
      m_change = m_credit;
      m_credit = 0;
      push_st(1'b0, 1'b0);
    end
`endif
    @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    @(negedge clock);
    cancel = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_totals("cancel");
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int r, s_len;
    logic [1:0] cv;
    bit found;
    repeat (3) @(negedge clock);
    check("reset_total", 32'(total_coins), 32'd0);
    check("reset_change", 32'(change), 32'd0);
    check("reset_valves", 32'({water, coffee, sugar, milk, chocolate}), 32'd0);
    check("reset_pulses", 32'({finished, coin_reject, sel_error}), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    mon_en = 1'b1;

    // directed: full type-3 brew with a coin during COFFEE
    do_coin(1'b0, 1'b1);
    do_coin(1'b0, 1'b1);
    do_confirm(3, 1'b1, 6);
    // credit cap: 9 + 5 rejected, 9 + 1 accepted
    do_coin(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_coin(1'b1, 1'b0);
    do_coin(1'b0, 1'b1);
    do_coin(1'b1, 1'b0);
    do_confirm(6, 1'b0, 0);
    do_confirm(2, 1'b0, 0);
    for (int i = 0; i < 3; i++) do_coin(1'b1, 1'b0);
    do_confirm(2, 1'b0, 0);
    do_confirm(0, 1'b0, 0);
    // cancel with credit 7
    do_coin(1'b0, 1'b1);
    do_coin(1'b1, 1'b0);
    do_coin(1'b1, 1'b0);
    do_cancel();
    do_cancel();

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4) begin
        cv = 2'($urandom_range(1, 3));
        do_coin(cv[0], cv[1]);
      end else if (r <= 7) begin
        do_confirm(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);
      end else begin
        do_cancel();
      end
    end

    // reset during the MILK step of a type-3 brew
    while (m_credit < 8) do_coin(1'b1, 1'b0);
    m_change = m_credit - 8;
    m_credit = 0;
    push_st(1'b0, 1'b0);
    vlv_exp_q.push_back({6'b100000, 6'b010000, 16'(TD)});
    vlv_exp_q.push_back({6'b010000, 6'b001000, 16'(2 * TD)});
    vlv_exp_q.push_back({6'b001000, 6'b000100, 16'(TD)});
    @(negedge clock);
    coffee_type = 3'd3;
    confirm = 1'b1;
    @(negedge clock);
    @(negedge clock);
    confirm = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clock);
      if (milk) found = 1'b1;
    end
    check("milk_reached", 32'(found), 32'd1);
    @(negedge clock);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midreset_milk", 32'(milk), 32'd0);
    check("midreset_valves", 32'({water, coffee, sugar, chocolate, finished}), 32'd0);
    check("midreset_credit", 32'({total_coins, change}), 32'd0);
    check("midreset_pulses", 32'({coin_reject, sel_error}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    m_credit = 0;
    m_change = 0;
    check_totals("post_reset");
    mon_en = 1'b1;
    do_coin(1'b1, 1'b0);
    repeat (3) @(negedge clock);

    check("status_queue_empty", 32'(st_exp_q.size()), 32'd0);
    check("valve_queue_empty", 32'(vlv_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/brew_sequencer.md
# brew_sequencer

Central controller for the coffee vending datapath. Accumulates coin credit, validates the selection against its price, and latches change. It then steps the ingredient valves (water, coffee, sugar, milk, chocolate) for recipe-defined durations and signals completion. It replaces the loose coin-counter/comparator/timer/FSM interconnect with a single sequenced block feeding the 7-segment display modules.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clock cycles per one-second tick; benches use 4.
- CREDIT_MAX, 10: credit ceiling in 100-unit coins (10 = 1000).

Ports:
- clock  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- coin_100  in  1  one-cycle pulse, +1 credit unit.
- coin_500  in  1  one-cycle pulse, +5 credit units.
- coffee_type  in  3  recipe select, valid 0..4.
- confirm  in  1  level; acted on at rising edge.
- cancel  in  1  level; acted on at rising edge (see Configuration).
- total_coins  out  4  current credit, to display.
- change  out  4  latched change, to display.
- water, coffee, sugar, milk, chocolate  out  1 each  valve enables.
- finished  out  1  brew complete.
- coin_reject  out  1  one-cycle pulse, coin not accepted.
- sel_error  out  1  one-cycle pulse, confirm refused.
- state  out  4  encoded FSM state, debug.

## Operation
- States: IDLE, WATER, COFFEE, SUGAR, MILK, CHOCOLATE, DONE, REFUND.
- Recipe table (price; water, coffee, sugar, milk, chocolate seconds):
  - 0 = 3; 1,2,0,0,0
  - 1 = 4; 3,2,0,0,0
  - 2 = 6; 1,2,1,2,0
  - 3 = 8; 1,2,1,1,2
  - 4 = 7; 1,2,0,3,0
- IDLE, coin insertion:
  - Credit adds 1/5/6 for coin_100 / coin_500 / both in the same cycle.
  - If the sum exceeds CREDIT_MAX, credit is unchanged and coin_reject pulses. The whole insertion is rejected, never a partial add.
  - Any accepted coin clears change to 0.
- IDLE, confirm edge:
  - If coffee_type ≤ 4 and credit ≥ price: change ← credit − price, credit ← 0, enter the first step with nonzero duration, in the order WATER→COFFEE→SUGAR→MILK→CHOCOLATE.
  - Otherwise sel_error pulses and state stays IDLE.
- coffee_type is captured at the confirm edge; later changes are ignored until IDLE.
- Each step asserts only its valve for duration×TICK_DIV cycles, then moves to the next nonzero step; after the last step, DONE.
- DONE: finished=1 for one tick (TICK_DIV cycles), then IDLE. change is held.
- While not IDLE, coins pulse coin_reject and are discarded; confirm and cancel are ignored.

## Timing
- Reset (async, low): state IDLE, credit 0, change 0, all valves 0, finished 0, pulses 0, tick prescaler 0.
- Release of reset is synchronized internally (two-flop) before leaving reset.
- All outputs are registered. A coin pulse in cycle n updates total_coins at n+1.
- confirm: input registered, edge detected at n+1, first valve high at n+2.
- The step timer restarts at each state entry. Valves never overlap; there are no zero-cycle gaps between steps.
- Reset mid-brew: valves drop immediately (async), credit and change are lost.

## Configuration
- COIN_REFUND_EN defined:
  - A cancel edge in IDLE with credit > 0 enters REFUND for one cycle: change ← credit, credit ← 0, then IDLE.
  - With credit 0, cancel does nothing.
- Undefined: cancel is ignored and REFUND is not synthesized. The port remains present.

## Structure
- vending_pkg holds:
  - the state enum;
  - the recipe struct (price, five durations) and recipe lookup function;
  - the CREDIT_MAX default;
  - coin value constants.
- Sub-module tick_timer (prescaler + seconds counter, restart input, `expired` compare against the target duration) is instantiated once.

## Test plan
- TICK_DIV=4. coin_500, coin_500, then confirm with type 3 → total_coins 10→0, change 2. Valves in order: water 4, coffee 8, sugar 4, milk 4, chocolate 8 cycles. finished high 4 cycles, then IDLE.
- Credit 9, then coin_500 → coin_reject pulses, total_coins stays 9. Then coin_100 → 10.
- Credit 3, confirm with type 2 → sel_error pulses, credit 3, state IDLE. Confirm with type 6 and credit 10 → sel_error.
- Type 0 with credit 3 → change 0. The sugar, milk and chocolate steps are skipped; DONE immediately follows COFFEE.
- Coin pulse during COFFEE → coin_reject, credit unchanged. Reset asserted mid-MILK → all outputs 0 within the same cycle.
- COIN_REFUND_EN: credit 7, cancel edge → change 7, total_coins 0. Without the macro, credit stays 7.
